// File: rtl/execute_ldst_queue_pkg.sv
// Shared types and load-data alignment for execute_ldst_queue.
// The signed-load variant is selected with EXECUTE_LDST_QUEUE_SIGNEXT_EN.
package execute_ldst_queue_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      ORDER_BYTE = 2'b00,
      ORDER_HALF = 2'b01,
      ORDER_WORD = 2'b10
   } order_e;

   // Per-request metadata held in the FIFO alongside tag and destination.
   typedef struct packed {
      logic       rw;
      logic       sgn;
      logic [1:0] order;
      logic [1:0] shift;
   } meta_t;

   localparam int META_W = $bits(meta_t);

   function automatic logic [DATA_W-1:0] alignLoad(
      input logic [DATA_W-1:0] data,
      input logic [1:0]        shift,
      input logic [1:0]        order,
      input logic              sgn
   );
      logic [DATA_W-1:0] w_shifted;
      logic [DATA_W-1:0] w_result;
      w_shifted = data >> {shift, 3'b000};
      case (order)
         ORDER_BYTE: w_result = {{24{sgn & w_shifted[7]}}, w_shifted[7:0]};
         ORDER_HALF: w_result = {{16{sgn & w_shifted[15]}}, w_shifted[15:0]};
         default:    w_result = w_shifted;
      endcase
      return w_result;
   endfunction

endpackage

// File: rtl/execute_ldst_queue_if.sv
// Scheduler, data-port and completion signals of execute_ldst_queue.
// iREQ_SIGNED exists only when EXECUTE_LDST_QUEUE_SIGNEXT_EN is defined.
interface execute_ldst_queue_if #(
   parameter int P_DEPTH = 4,
   parameter int P_TAG_W = 6,
   parameter int P_REG_W = 6
);
   logic                     iFLUSH;
   logic                     iREQ_VALID;
   logic                     oREQ_LOCK;
   logic                     iREQ_RW;
   logic [31:0]              iREQ_ADDR;
   logic [31:0]              iREQ_DATA;
   logic [3:0]               iREQ_MASK;
   logic [1:0]               iREQ_ORDER;
   logic [1:0]               iREQ_SHIFT;
   logic [P_TAG_W-1:0]       iREQ_TAG;
   logic [P_REG_W-1:0]       iREQ_DEST;
`ifdef EXECUTE_LDST_QUEUE_SIGNEXT_EN
   logic                     iREQ_SIGNED;
`endif
   logic                     oDATAIO_REQ;
   logic                     iDATAIO_BUSY;
   logic                     oDATAIO_RW;
   logic [31:0]              oDATAIO_ADDR;
   logic [31:0]              oDATAIO_DATA;
   logic [3:0]               oDATAIO_MASK;
   logic [1:0]               oDATAIO_ORDER;
   logic                     iDATAIO_REQ;
   logic [31:0]              iDATAIO_DATA;
   logic                     oDONE_VALID;
   logic [P_TAG_W-1:0]       oDONE_TAG;
   logic [P_REG_W-1:0]       oDONE_DEST;
   logic                     oDONE_WRITEBACK;
   logic [31:0]              oDONE_DATA;
   logic [$clog2(P_DEPTH):0] oCOUNT;
   logic                     oERR;

   modport slave (
`ifdef EXECUTE_LDST_QUEUE_SIGNEXT_EN
      input  iREQ_SIGNED,
`endif
      input  iFLUSH, iREQ_VALID, iREQ_RW, iREQ_ADDR, iREQ_DATA, iREQ_MASK,
             iREQ_ORDER, iREQ_SHIFT, iREQ_TAG, iREQ_DEST,
             iDATAIO_BUSY, iDATAIO_REQ, iDATAIO_DATA,
      output oREQ_LOCK, oDATAIO_REQ, oDATAIO_RW, oDATAIO_ADDR, oDATAIO_DATA,
             oDATAIO_MASK, oDATAIO_ORDER, oDONE_VALID, oDONE_TAG, oDONE_DEST,
             oDONE_WRITEBACK, oDONE_DATA, oCOUNT, oERR
   );

   modport master (
`ifdef EXECUTE_LDST_QUEUE_SIGNEXT_EN
      output iREQ_SIGNED,
`endif
      output iFLUSH, iREQ_VALID, iREQ_RW, iREQ_ADDR, iREQ_DATA, iREQ_MASK,
             iREQ_ORDER, iREQ_SHIFT, iREQ_TAG, iREQ_DEST,
             iDATAIO_BUSY, iDATAIO_REQ, iDATAIO_DATA,
      input  oREQ_LOCK, oDATAIO_REQ, oDATAIO_RW, oDATAIO_ADDR, oDATAIO_DATA,
             oDATAIO_MASK, oDATAIO_ORDER, oDONE_VALID, oDONE_TAG, oDONE_DEST,
             oDONE_WRITEBACK, oDONE_DATA, oCOUNT, oERR
   );

endinterface

// File: rtl/execute_ldst_queue_fifo.sv
// Synchronous FIFO with occupancy count and a broadcast kill that marks
// every stored entry (including one written in the same cycle) as killed.
module execute_ldst_queue_fifo #(
   parameter int P_DEPTH = 4,
   parameter int P_WIDTH = 8,
   localparam int PTR_W  = $clog2(P_DEPTH),
   localparam int CNT_W  = $clog2(P_DEPTH) + 1
) (
   input  logic               iCLOCK,
   input  logic               iRESET_SYNC,
   input  logic               i_push,
   input  logic [P_WIDTH-1:0] i_pushData,
   input  logic               i_pop,
   input  logic               i_kill,
   output logic [P_WIDTH-1:0] o_headData,
   output logic               o_headKilled,
   output logic               o_full,
   output logic               o_empty,
   output logic [CNT_W-1:0]   o_count
);

   logic [P_WIDTH-1:0] r_mem [P_DEPTH];
   logic [P_DEPTH-1:0] r_killed;
   logic [PTR_W-1:0]   r_wrPtr;
   logic [PTR_W-1:0]   r_rdPtr;
   logic [CNT_W-1:0]   r_count;
   logic               w_doPush;
   logic               w_doPop;

   assign o_empty      = (r_count == '0);
   assign o_full       = (r_count == CNT_W'(P_DEPTH));
   assign w_doPop      = i_pop && !o_empty;
   assign w_doPush     = i_push && (!o_full || w_doPop);
   assign o_headData   = r_mem[r_rdPtr];
   assign o_headKilled = r_killed[r_rdPtr];
   assign o_count      = r_count;

   always_ff @(posedge iCLOCK) begin
      if (w_doPush) begin
         r_mem[r_wrPtr] <= i_pushData;
      end
   end

   // Kill wins over a same-cycle push so a freshly written entry is also marked.
   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) begin
         r_wrPtr  <= '0;
         r_rdPtr  <= '0;
         r_count  <= '0;
         r_killed <= '0;
      end else begin
         if (w_doPush) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_doPop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         if (i_kill) begin
            r_killed <= '1;
         end else if (w_doPush) begin
            r_killed[r_wrPtr] <= 1'b0;
         end
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/execute_ldst_queue.sv
// Pipelined load/store execute port: one issue register in front of the data
// port, an in-order metadata FIFO of outstanding requests, registered completion.
// Define EXECUTE_LDST_QUEUE_SIGNEXT_EN to enable signed byte/half loads.
module execute_ldst_queue
   import execute_ldst_queue_pkg::*;
#(
   parameter int P_DEPTH = 4,
   parameter int P_TAG_W = 6,
   parameter int P_REG_W = 6
) (
   input logic                 iCLOCK,
   input logic                 iRESET_SYNC,
   execute_ldst_queue_if.slave bus
);

   localparam int CNT_W   = $clog2(P_DEPTH) + 1;
   localparam int ENTRY_W = META_W + P_TAG_W + P_REG_W;

   logic               r_issueValid;
   logic               r_rw;
   logic               r_sgn;
   logic [31:0]        r_addr;
   logic [31:0]        r_data;
   logic [3:0]         r_mask;
   logic [1:0]         r_order;
   logic [1:0]         r_shift;
   logic [P_TAG_W-1:0] r_tag;
   logic [P_REG_W-1:0] r_dest;

   logic               r_doneValid;
   logic [P_TAG_W-1:0] r_doneTag;
   logic [P_REG_W-1:0] r_doneDest;
   logic               r_doneWb;
   logic [31:0]        r_doneData;
   logic               r_err;

   logic               w_reqSigned;
   logic               w_empty;
   logic               w_full;
   logic               w_headKilled;
   logic [ENTRY_W-1:0] w_headData;
   logic [ENTRY_W-1:0] w_pushData;
   logic [CNT_W-1:0]   w_count;
   meta_t              w_pushMeta;
   meta_t              w_headMeta;
   logic [P_TAG_W-1:0] w_headTag;
   logic [P_REG_W-1:0] w_headDest;
   logic               w_pop;
   logic               w_respErr;
   logic               w_issueFire;
   logic               w_lock;
   logic               w_accept;
   logic               w_complete;

`ifdef EXECUTE_LDST_QUEUE_SIGNEXT_EN
   assign w_reqSigned = bus.iREQ_SIGNED;
`else
   assign w_reqSigned = 1'b0;
`endif

   // A response may free the slot the issuing request needs in the same cycle.
   assign w_pop       = bus.iDATAIO_REQ && !w_empty;
   assign w_respErr   = bus.iDATAIO_REQ && w_empty;
   assign w_issueFire = r_issueValid && !bus.iDATAIO_BUSY && (!w_full || w_pop)
                        && !bus.iFLUSH && !iRESET_SYNC;
   assign w_lock      = r_issueValid && !w_issueFire;
   assign w_accept    = bus.iREQ_VALID && !w_lock && !bus.iFLUSH;
   assign w_complete  = w_pop && !w_headKilled && !bus.iFLUSH;

   assign w_pushMeta  = '{rw: r_rw, sgn: r_sgn, order: r_order, shift: r_shift};
   assign w_pushData  = {w_pushMeta, r_tag, r_dest};
   assign {w_headMeta, w_headTag, w_headDest} = w_headData;

   execute_ldst_queue_fifo #(
      .P_DEPTH (P_DEPTH),
      .P_WIDTH (ENTRY_W)
   ) u_fifo (
      .iCLOCK       (iCLOCK),
      .iRESET_SYNC  (iRESET_SYNC),
      .i_push       (w_issueFire),
      .i_pushData   (w_pushData),
      .i_pop        (w_pop),
      .i_kill       (bus.iFLUSH),
      .o_headData   (w_headData),
      .o_headKilled (w_headKilled),
      .o_full       (w_full),
      .o_empty      (w_empty),
      .o_count      (w_count)
   );

   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) begin
         r_issueValid <= 1'b0;
         r_rw         <= 1'b0;
         r_sgn        <= 1'b0;
         r_addr       <= '0;
         r_data       <= '0;
         r_mask       <= '0;
         r_order      <= '0;
         r_shift      <= '0;
         r_tag        <= '0;
         r_dest       <= '0;
      end else if (bus.iFLUSH) begin
         r_issueValid <= 1'b0;
      end else if (w_accept) begin
         r_issueValid <= 1'b1;
         r_rw         <= bus.iREQ_RW;
         r_sgn        <= w_reqSigned;
         r_addr       <= bus.iREQ_ADDR;
         r_data       <= bus.iREQ_DATA;
         r_mask       <= bus.iREQ_MASK;
         r_order      <= bus.iREQ_ORDER;
         r_shift      <= bus.iREQ_SHIFT;
         r_tag        <= bus.iREQ_TAG;
         r_dest       <= bus.iREQ_DEST;
      end else if (w_issueFire) begin
         r_issueValid <= 1'b0;
      end
   end

   // Completion fields only change on a live completion; stores return zero data.
   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) begin
         r_doneValid <= 1'b0;
         r_doneTag   <= '0;
         r_doneDest  <= '0;
         r_doneWb    <= 1'b0;
         r_doneData  <= '0;
         r_err       <= 1'b0;
      end else begin
         r_doneValid <= w_complete;
         if (w_complete) begin
            r_doneTag  <= w_headTag;
            r_doneDest <= w_headDest;
            r_doneWb   <= !w_headMeta.rw;
            r_doneData <= w_headMeta.rw ? 32'h0 :
                          alignLoad(bus.iDATAIO_DATA, w_headMeta.shift,
                                    w_headMeta.order, w_headMeta.sgn);
         end
         if (w_respErr) begin
            r_err <= 1'b1;
         end
      end
   end

   assign bus.oREQ_LOCK       = w_lock;
   assign bus.oDATAIO_REQ     = w_issueFire;
   assign bus.oDATAIO_RW      = r_rw;
   assign bus.oDATAIO_ADDR    = r_addr;
   assign bus.oDATAIO_DATA    = r_data;
   assign bus.oDATAIO_MASK    = r_mask;
   assign bus.oDATAIO_ORDER   = r_order;
   assign bus.oDONE_VALID     = r_doneValid;
   assign bus.oDONE_TAG       = r_doneTag;
   assign bus.oDONE_DEST      = r_doneDest;
   assign bus.oDONE_WRITEBACK = r_doneWb;
   assign bus.oDONE_DATA      = r_doneData;
   assign bus.oCOUNT          = w_count;
   assign bus.oERR            = r_err;

endmodule

// File: tb/tb_execute_ldst_queue.sv
// Directed testbench for execute_ldst_queue (P_DEPTH=4).
// Expectations follow EXECUTE_LDST_QUEUE_SIGNEXT_EN when it is defined.
module tb_execute_ldst_queue;
   import execute_ldst_queue_pkg::*;

`ifdef EXECUTE_LDST_QUEUE_SIGNEXT_EN
   localparam bit SIGNEXT_ON = 1'b1;
`else
   localparam bit SIGNEXT_ON = 1'b0;
`endif

   logic iCLOCK = 1'b0;
   logic iRESET_SYNC;
   int   checkCount = 0;
   int   errorCount = 0;

   execute_ldst_queue_if #(.P_DEPTH(4), .P_TAG_W(6), .P_REG_W(6)) bus ();

   execute_ldst_queue #(.P_DEPTH(4), .P_TAG_W(6), .P_REG_W(6)) dut (
      .iCLOCK      (iCLOCK),
      .iRESET_SYNC (iRESET_SYNC),
      .bus         (bus)
   );

   always #5 iCLOCK = ~iCLOCK;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   task automatic clearInputs();
      bus.iFLUSH       = 1'b0;
      bus.iREQ_VALID   = 1'b0;
      bus.iREQ_RW      = 1'b0;
      bus.iREQ_ADDR    = '0;
      bus.iREQ_DATA    = '0;
      bus.iREQ_MASK    = '0;
      bus.iREQ_ORDER   = '0;
      bus.iREQ_SHIFT   = '0;
      bus.iREQ_TAG     = '0;
      bus.iREQ_DEST    = '0;
      bus.iDATAIO_BUSY = 1'b0;
      bus.iDATAIO_REQ  = 1'b0;
      bus.iDATAIO_DATA = '0;
`ifdef EXECUTE_LDST_QUEUE_SIGNEXT_EN
      bus.iREQ_SIGNED  = 1'b0;
`endif
   endtask

   task automatic setRequest(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] mask, input logic [1:0] order, input logic [1:0] shift,
                             input logic [5:0] tag, input logic [5:0] dest);
      bus.iREQ_VALID = 1'b1;
      bus.iREQ_RW    = rw;
      bus.iREQ_ADDR  = addr;
      bus.iREQ_DATA  = wdata;
      bus.iREQ_MASK  = mask;
      bus.iREQ_ORDER = order;
      bus.iREQ_SHIFT = shift;
      bus.iREQ_TAG   = tag;
      bus.iREQ_DEST  = dest;
   endtask

   // One isolated transaction: accept, issue, respond, completion.
   task automatic applyStimulus(input string name, input logic rw, input logic [1:0] order,
                                input logic [1:0] shift, input logic sgn, input logic [3:0] mask,
                                input logic [31:0] addr, input logic [31:0] wdata, input logic [5:0] tag,
                                input logic [31:0] resp, input logic [31:0] expUnsigned,
                                input logic [31:0] expSigned);
      logic [31:0] expData;
      expData = (sgn && SIGNEXT_ON) ? expSigned : expUnsigned;
      @(negedge iCLOCK);
      setRequest(rw, addr, wdata, mask, order, shift, tag, tag + 6'd1);
`ifdef EXECUTE_LDST_QUEUE_SIGNEXT_EN
      bus.iREQ_SIGNED = sgn;
`endif
      @(negedge iCLOCK);
      bus.iREQ_VALID = 1'b0;
      #1;
      checkOutput({name, ".req"},   32'(bus.oDATAIO_REQ),   32'd1);
      checkOutput({name, ".rw"},    32'(bus.oDATAIO_RW),    32'(rw));
      checkOutput({name, ".addr"},  bus.oDATAIO_ADDR,       addr);
      checkOutput({name, ".wdata"}, bus.oDATAIO_DATA,       wdata);
      checkOutput({name, ".mask"},  32'(bus.oDATAIO_MASK),  32'(mask));
      checkOutput({name, ".order"}, 32'(bus.oDATAIO_ORDER), 32'(order));
      @(negedge iCLOCK);
      bus.iDATAIO_REQ  = 1'b1;
      bus.iDATAIO_DATA = resp;
      @(negedge iCLOCK);
      bus.iDATAIO_REQ  = 1'b0;
      #1;
      checkOutput({name, ".doneValid"}, 32'(bus.oDONE_VALID),     32'd1);
      checkOutput({name, ".doneTag"},   32'(bus.oDONE_TAG),       32'(tag));
      checkOutput({name, ".doneDest"},  32'(bus.oDONE_DEST),      32'(tag + 6'd1));
      checkOutput({name, ".doneWb"},    32'(bus.oDONE_WRITEBACK), 32'(!rw));
      checkOutput({name, ".doneData"},  bus.oDONE_DATA,           expData);
      checkOutput({name, ".count"},     32'(bus.oCOUNT),          32'd0);
   endtask

   initial begin
      clearInputs();
      iRESET_SYNC = 1'b1;
      repeat (2) @(negedge iCLOCK);
      #1;
      checkOutput("rst.doneValid", 32'(bus.oDONE_VALID), 32'd0);
      checkOutput("rst.doneData",  bus.oDONE_DATA,       32'd0);
      checkOutput("rst.count",     32'(bus.oCOUNT),      32'd0);
      checkOutput("rst.err",       32'(bus.oERR),        32'd0);
      checkOutput("rst.lock",      32'(bus.oREQ_LOCK),   32'd0);
      checkOutput("rst.dataioReq", 32'(bus.oDATAIO_REQ), 32'd0);
      iRESET_SYNC = 1'b0;

      // Back-to-back word loads, one accepted and one issued per cycle.
      for (int i = 0; i < 4; i++) begin
         @(negedge iCLOCK);
         setRequest(1'b0, 32'h100 + 32'(4 * i), 32'h0, 4'hF, ORDER_WORD, 2'd0, 6'(i + 1), 6'(i + 20));
         #1;
         checkOutput("b2b.lock", 32'(bus.oREQ_LOCK), 32'd0);
         if (i > 0) checkOutput("b2b.addr", bus.oDATAIO_ADDR, 32'h100 + 32'(4 * (i - 1)));
      end
      @(negedge iCLOCK);
      bus.iREQ_VALID = 1'b0;
      #1;
      checkOutput("b2b.lastReq",  32'(bus.oDATAIO_REQ), 32'd1);
      checkOutput("b2b.lastAddr", bus.oDATAIO_ADDR,     32'h10C);
      checkOutput("b2b.count3",   32'(bus.oCOUNT),      32'd3);
      @(negedge iCLOCK);
      #1;
      checkOutput("b2b.count4", 32'(bus.oCOUNT),      32'd4);
      checkOutput("b2b.idle",   32'(bus.oDATAIO_REQ), 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge iCLOCK);
         bus.iDATAIO_REQ  = 1'b1;
         bus.iDATAIO_DATA = 32'hCAFE_0000 + 32'(i);
         #1;
         if (i > 0) begin
            checkOutput("b2b.doneValid", 32'(bus.oDONE_VALID),     32'd1);
            checkOutput("b2b.doneTag",   32'(bus.oDONE_TAG),       32'(i));
            checkOutput("b2b.doneDest",  32'(bus.oDONE_DEST),      32'(i + 19));
            checkOutput("b2b.doneWb",    32'(bus.oDONE_WRITEBACK), 32'd1);
            checkOutput("b2b.doneData",  bus.oDONE_DATA,           32'hCAFE_0000 + 32'(i - 1));
         end
      end
      @(negedge iCLOCK);
      bus.iDATAIO_REQ = 1'b0;
      #1;
      checkOutput("b2b.lastTag",  32'(bus.oDONE_TAG), 32'd4);
      checkOutput("b2b.lastData", bus.oDONE_DATA,     32'hCAFE_0003);
      checkOutput("b2b.drained",  32'(bus.oCOUNT),    32'd0);
      @(negedge iCLOCK);
      #1;
      checkOutput("b2b.quiet", 32'(bus.oDONE_VALID), 32'd0);

      // Full boundary: the fifth request waits until a response frees a slot.
      for (int i = 0; i < 5; i++) begin
         @(negedge iCLOCK);
         setRequest(1'b0, 32'h200 + 32'(4 * i), 32'h0, 4'hF, ORDER_WORD, 2'd0, 6'(i + 10), 6'(i + 30));
         #1;
         checkOutput("full.accLock", 32'(bus.oREQ_LOCK), 32'd0);
      end
      @(negedge iCLOCK);
      bus.iREQ_VALID = 1'b0;
      #1;
      checkOutput("full.lock",  32'(bus.oREQ_LOCK),   32'd1);
      checkOutput("full.noReq", 32'(bus.oDATAIO_REQ), 32'd0);
      checkOutput("full.count", 32'(bus.oCOUNT),      32'd4);
      @(negedge iCLOCK);
      #1;
      checkOutput("full.lockHeld", 32'(bus.oREQ_LOCK), 32'd1);
      @(negedge iCLOCK);
      bus.iDATAIO_REQ  = 1'b1;
      bus.iDATAIO_DATA = 32'h0000_0055;
      #1;
      checkOutput("full.popReq",  32'(bus.oDATAIO_REQ), 32'd1);
      checkOutput("full.popLock", 32'(bus.oREQ_LOCK),   32'd0);
      checkOutput("full.popAddr", bus.oDATAIO_ADDR,     32'h210);
      @(negedge iCLOCK);
      bus.iDATAIO_REQ = 1'b0;
      #1;
      checkOutput("full.countHeld", 32'(bus.oCOUNT),      32'd4);
      checkOutput("full.doneValid", 32'(bus.oDONE_VALID), 32'd1);
      checkOutput("full.doneTag",   32'(bus.oDONE_TAG),   32'd10);
      for (int i = 0; i < 4; i++) begin
         @(negedge iCLOCK);
         bus.iDATAIO_REQ  = 1'b1;
         bus.iDATAIO_DATA = 32'h0000_0060 + 32'(i);
         #1;
         if (i > 0) checkOutput("full.drainTag", 32'(bus.oDONE_TAG), 32'(i + 10));
      end
      @(negedge iCLOCK);
      bus.iDATAIO_REQ = 1'b0;
      #1;
      checkOutput("full.lastTag", 32'(bus.oDONE_TAG), 32'd14);
      checkOutput("full.drained", 32'(bus.oCOUNT),    32'd0);

      // Alignment, sign handling and store completion.
      applyStimulus("byte",  1'b0, ORDER_BYTE, 2'd2, 1'b0, 4'h4, 32'h302, 32'h0, 6'd5,
                    32'hAABB_CCDD, 32'h0000_00BB, 32'h0000_00BB);
      applyStimulus("half",  1'b0, ORDER_HALF, 2'd2, 1'b0, 4'hC, 32'h302, 32'h0, 6'd6,
                    32'hAABB_CCDD, 32'h0000_AABB, 32'h0000_AABB);
      applyStimulus("sbyte", 1'b0, ORDER_BYTE, 2'd2, 1'b1, 4'h4, 32'h302, 32'h0, 6'd7,
                    32'hAABB_CCDD, 32'h0000_00BB, 32'hFFFF_FFBB);
      applyStimulus("shalf", 1'b0, ORDER_HALF, 2'd2, 1'b1, 4'hC, 32'h302, 32'h0, 6'd8,
                    32'hAABB_CCDD, 32'h0000_AABB, 32'hFFFF_AABB);
      applyStimulus("sbpos", 1'b0, ORDER_BYTE, 2'd0, 1'b1, 4'h1, 32'h300, 32'h0, 6'd9,
                    32'h1234_567F, 32'h0000_007F, 32'h0000_007F);
      applyStimulus("word",  1'b0, ORDER_WORD, 2'd0, 1'b0, 4'hF, 32'h300, 32'h0, 6'd12,
                    32'hAABB_CCDD, 32'hAABB_CCDD, 32'hAABB_CCDD);
      applyStimulus("store", 1'b1, ORDER_HALF, 2'd0, 1'b0, 4'b0011, 32'h308, 32'h0000_BEEF, 6'd13,
                    32'h1234_5678, 32'h0000_0000, 32'h0000_0000);

      // Flush with three outstanding and one waiting in the issue register.
      for (int i = 0; i < 4; i++) begin
         @(negedge iCLOCK);
         setRequest(1'b0, 32'h400 + 32'(4 * i), 32'h0, 4'hF, ORDER_WORD, 2'd0, 6'(i + 40), 6'(i + 1));
      end
      @(negedge iCLOCK);
      bus.iREQ_VALID = 1'b0;
      bus.iFLUSH     = 1'b1;
      #1;
      checkOutput("flush.blockReq", 32'(bus.oDATAIO_REQ), 32'd0);
      @(negedge iCLOCK);
      bus.iFLUSH = 1'b0;
      #1;
      checkOutput("flush.issueCleared", 32'(bus.oDATAIO_REQ), 32'd0);
      checkOutput("flush.lock",         32'(bus.oREQ_LOCK),   32'd0);
      checkOutput("flush.count",        32'(bus.oCOUNT),      32'd3);
      for (int i = 0; i < 3; i++) begin
         @(negedge iCLOCK);
         bus.iDATAIO_REQ  = 1'b1;
         bus.iDATAIO_DATA = 32'h0000_0077;
         #1;
         if (i > 0) checkOutput("flush.noDone", 32'(bus.oDONE_VALID), 32'd0);
      end
      @(negedge iCLOCK);
      bus.iDATAIO_REQ = 1'b0;
      #1;
      checkOutput("flush.noDoneLast", 32'(bus.oDONE_VALID), 32'd0);
      checkOutput("flush.drained",    32'(bus.oCOUNT),      32'd0);
      @(negedge iCLOCK);
      setRequest(1'b0, 32'h480, 32'h0, 4'hF, ORDER_WORD, 2'd0, 6'd44, 6'd4);
      bus.iFLUSH = 1'b1;
      @(negedge iCLOCK);
      bus.iREQ_VALID = 1'b0;
      bus.iFLUSH     = 1'b0;
      #1;
      checkOutput("flush.rejected", 32'(bus.oDATAIO_REQ), 32'd0);

      // Busy data port stalls the issue register.
      @(negedge iCLOCK);
      setRequest(1'b0, 32'h500, 32'h0, 4'hF, ORDER_WORD, 2'd0, 6'd50, 6'd51);
      @(negedge iCLOCK);
      bus.iREQ_VALID   = 1'b0;
      bus.iDATAIO_BUSY = 1'b1;
      #1;
      checkOutput("busy.noReq", 32'(bus.oDATAIO_REQ), 32'd0);
      checkOutput("busy.lock",  32'(bus.oREQ_LOCK),   32'd1);
      @(negedge iCLOCK);
      bus.iDATAIO_BUSY = 1'b0;
      #1;
      checkOutput("busy.req",  32'(bus.oDATAIO_REQ), 32'd1);
      checkOutput("busy.addr", bus.oDATAIO_ADDR,     32'h500);
      @(negedge iCLOCK);
      bus.iDATAIO_REQ  = 1'b1;
      bus.iDATAIO_DATA = 32'h0000_0005;
      @(negedge iCLOCK);
      bus.iDATAIO_REQ = 1'b0;
      #1;
      checkOutput("busy.doneTag", 32'(bus.oDONE_TAG), 32'd50);

      applyStimulus("postFlush", 1'b0, ORDER_WORD, 2'd0, 1'b0, 4'hF, 32'h600, 32'h0, 6'd60,
                    32'h600D_F00D, 32'h600D_F00D, 32'h600D_F00D);

      // Response with nothing outstanding.
      @(negedge iCLOCK);
      bus.iDATAIO_REQ  = 1'b1;
      bus.iDATAIO_DATA = 32'hDEAD_BEEF;
      @(negedge iCLOCK);
      bus.iDATAIO_REQ = 1'b0;
      #1;
      checkOutput("err.set",    32'(bus.oERR),        32'd1);
      checkOutput("err.noDone", 32'(bus.oDONE_VALID), 32'd0);
      checkOutput("err.count",  32'(bus.oCOUNT),      32'd0);
      @(negedge iCLOCK);
      #1;
      checkOutput("err.sticky", 32'(bus.oERR), 32'd1);

      // Reset with one request outstanding and another in the issue register.
      @(negedge iCLOCK);
      setRequest(1'b0, 32'h700, 32'h0, 4'hF, ORDER_WORD, 2'd0, 6'd61, 6'd62);
      @(negedge iCLOCK);
      setRequest(1'b0, 32'h704, 32'h0, 4'hF, ORDER_WORD, 2'd0, 6'd63, 6'd62);
      @(negedge iCLOCK);
      bus.iREQ_VALID = 1'b0;
      iRESET_SYNC    = 1'b1;
      @(negedge iCLOCK);
      iRESET_SYNC = 1'b0;
      #1;
      checkOutput("midRst.count",    32'(bus.oCOUNT),      32'd0);
      checkOutput("midRst.err",      32'(bus.oERR),        32'd0);
      checkOutput("midRst.lock",     32'(bus.oREQ_LOCK),   32'd0);
      checkOutput("midRst.req",      32'(bus.oDATAIO_REQ), 32'd0);
      checkOutput("midRst.addr",     bus.oDATAIO_ADDR,     32'd0);
      checkOutput("midRst.doneTag",  32'(bus.oDONE_TAG),   32'd0);
      checkOutput("midRst.doneData", bus.oDONE_DATA,       32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
